// File: rtl/instr_ram_fetch_ctrl_if.sv
// Signal bundle between the fetch controller, the core fetch port, the
// loader write port and the single-port instruction RAM.
interface instr_ram_fetch_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 15
);
  logic                  fetch_en_i;
  logic                  branch_i;
  logic [ADDR_WIDTH-1:0] branch_addr_i;
  logic                  instr_valid_o;
  logic                  instr_ready_i;
  logic [31:0]           instr_rdata_o;
  logic [ADDR_WIDTH-1:0] instr_addr_o;
  logic                  ld_req_i;
  logic [ADDR_WIDTH-1:0] ld_addr_i;
  logic [31:0]           ld_wdata_i;
  logic [3:0]            ld_be_i;
  logic                  ld_gnt_o;
  logic                  ram_en_o;
  logic                  ram_we_o;
  logic [ADDR_WIDTH-1:0] ram_addr_o;
  logic [31:0]           ram_wdata_o;
  logic [3:0]            ram_be_o;
  logic [31:0]           ram_rdata_i;

  // Controller side
  modport master (
    input  fetch_en_i, branch_i, branch_addr_i, instr_ready_i,
           ld_req_i, ld_addr_i, ld_wdata_i, ld_be_i, ram_rdata_i,
    output instr_valid_o, instr_rdata_o, instr_addr_o, ld_gnt_o,
           ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_be_o
  );

  // Core / loader / RAM side
  modport slave (
    output fetch_en_i, branch_i, branch_addr_i, instr_ready_i,
           ld_req_i, ld_addr_i, ld_wdata_i, ld_be_i, ram_rdata_i,
    input  instr_valid_o, instr_rdata_o, instr_addr_o, ld_gnt_o,
           ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o, ram_be_o
  );
endinterface

// File: rtl/instr_ram_fetch_ctrl.sv
// Instruction fetch/prefetch controller in front of a single-port RAM with
// 1-cycle read latency. Loader writes take priority over fetch reads; a
// branch flushes the prefetch buffer and restarts fetch at the target.
module instr_ram_fetch_ctrl #(
  parameter int unsigned RAM_SIZE   = 32768,
  parameter int unsigned ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned BOOT_ADDR  = 0
) (
  input  logic                   clk,
  input  logic                   rstn_i,
  instr_ram_fetch_ctrl_if.master bus
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [31:0] BOOT_WORD = BOOT_ADDR & 32'hFFFF_FFFC;
  localparam logic [ADDR_WIDTH-1:0] BOOT_PC = BOOT_WORD[ADDR_WIDTH-1:0];

  logic [ADDR_WIDTH-1:0] pc;
  logic                  rd_pend;
  logic [ADDR_WIDTH-1:0] pend_addr;
  logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
  logic [31:0]           fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;

  logic [ADDR_WIDTH-1:0] tgt;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [CNT_W:0]        occupancy;
  logic                  credit;
  logic                  rd;
  logic                  rd_seq;
  logic                  pop;
  logic                  push;
  logic                  valid;
  logic                  unused_low_bits;

  assign unused_low_bits = ^{bus.branch_addr_i[1:0], bus.ld_addr_i[1:0]};

  assign tgt     = {bus.branch_addr_i[ADDR_WIDTH-1:2], 2'b00};
  assign rd_addr = bus.branch_i ? tgt : pc;

  assign valid = (count != '0);
  assign pop   = valid & bus.instr_ready_i;

  // Buffered words plus the in-flight read, less the word leaving this cycle.
  assign occupancy = (CNT_W+1)'(count) + (CNT_W+1)'(rd_pend) - (CNT_W+1)'(pop);
  assign credit    = occupancy < (CNT_W+1)'(FIFO_DEPTH);

  assign rd_seq = ~bus.ld_req_i & ~bus.branch_i & bus.fetch_en_i & credit;
  assign rd     = ~bus.ld_req_i & (bus.branch_i | (bus.fetch_en_i & credit));

  // The read issued last cycle returns its data this cycle, so a branch in
  // this cycle drops that word directly instead of via a registered kill.
  assign push = rd_pend & ~bus.branch_i;

  assign bus.ld_gnt_o      = bus.ld_req_i;
  assign bus.instr_valid_o = valid;
  assign bus.instr_rdata_o = valid ? fifo_data[rd_ptr] : '0;
  assign bus.instr_addr_o  = valid ? fifo_addr[rd_ptr] : '0;

  // RAM pin mux: loader write, else branch/sequential read, else idle.
  always_comb begin
    bus.ram_en_o    = 1'b0;
    bus.ram_we_o    = 1'b0;
    bus.ram_addr_o  = '0;
    bus.ram_wdata_o = '0;
    bus.ram_be_o    = '0;
    if (rstn_i) begin
      if (bus.ld_req_i) begin
        bus.ram_en_o    = 1'b1;
        bus.ram_we_o    = 1'b1;
        bus.ram_addr_o  = {bus.ld_addr_i[ADDR_WIDTH-1:2], 2'b00};
        bus.ram_wdata_o = bus.ld_wdata_i;
        bus.ram_be_o    = bus.ld_be_i;
      end else if (rd) begin
        bus.ram_en_o   = 1'b1;
        bus.ram_addr_o = rd_addr;
        bus.ram_be_o   = 4'hF;
      end
    end
  end

  // Fetch pointer and pending-read tracking.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      pc        <= BOOT_PC;
      rd_pend   <= 1'b0;
      pend_addr <= '0;
    end else begin
      rd_pend   <= rd;
      pend_addr <= rd_addr;
      if (bus.branch_i) begin
        pc <= bus.ld_req_i ? tgt : tgt + ADDR_WIDTH'(4);
      end else if (rd_seq) begin
        pc <= pc + ADDR_WIDTH'(4);
      end
    end
  end

  // Prefetch buffer pointers and occupancy; a branch empties the buffer.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.branch_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Prefetch buffer storage; outputs are masked while empty, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= pend_addr;
      fifo_data[wr_ptr] <= bus.ram_rdata_i;
    end
  end
endmodule

// File: tb/tb_instr_ram_fetch_ctrl.sv
// Self-checking bench for instr_ram_fetch_ctrl: a behavioural RAM, an
// outstanding-word/stream-address reference model and directed scenarios
// followed by randomized traffic.
module tb_instr_ram_fetch_ctrl;
  localparam int unsigned RAM_SIZE = 32768;
  localparam int unsigned AW       = 15;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned BOOT     = 0;
  localparam int unsigned WORDS    = RAM_SIZE / 4;

  logic clk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   errors = 0;

  logic [31:0]   mem [WORDS];
  logic [AW-1:0] m_exp;
  logic [AW-1:0] m_issue;
  logic [AW-1:0] m_tgt;
  int            m_out;
  logic          m_credit;

  instr_ram_fetch_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  instr_ram_fetch_ctrl #(
    .RAM_SIZE(RAM_SIZE), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .BOOT_ADDR(BOOT)
  ) dut (
    .clk(clk), .rstn_i(rstn), .bus(bus.master)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM; junk on the read bus when no read was done.
  always @(posedge clk) begin
    if (bus.ram_en_o && bus.ram_we_o) begin
      for (int b = 0; b < 4; b++)
        if (bus.ram_be_o[b]) mem[bus.ram_addr_o[AW-1:2]][8*b +: 8] = bus.ram_wdata_o[8*b +: 8];
      bus.ram_rdata_i <= $urandom;
    end else if (bus.ram_en_o) begin
      bus.ram_rdata_i <= mem[bus.ram_addr_o[AW-1:2]];
    end else begin
      bus.ram_rdata_i <= $urandom;
    end
  end

  // Reference model: words must come out in stream order with RAM contents;
  // reads are predicted from loader/branch priority and outstanding words.
  always @(negedge clk) begin
    if (!rstn) begin
      m_exp   = AW'(BOOT);
      m_issue = AW'(BOOT);
      m_out   = 0;
    end else begin
      if (bus.instr_valid_o && bus.instr_ready_i) begin
        checks++;
        if (bus.instr_addr_o !== m_exp) begin
          errors++; $display("FAIL mon_order: got addr %h want %h", bus.instr_addr_o, m_exp);
        end
        checks++;
        if (bus.instr_rdata_o !== mem[m_exp[AW-1:2]]) begin
          errors++; $display("FAIL mon_data: addr %h got %h want %h", m_exp, bus.instr_rdata_o, mem[m_exp[AW-1:2]]);
        end
        m_exp = m_exp + AW'(4);
        m_out--;
      end
      checks++;
      if (bus.ld_gnt_o !== bus.ld_req_i) begin
        errors++; $display("FAIL mon_gnt: got %b want %b", bus.ld_gnt_o, bus.ld_req_i);
      end
      m_tgt    = {bus.branch_addr_i[AW-1:2], 2'b00};
      m_credit = bus.fetch_en_i && (m_out < int'(DEPTH));
      checks++;
      if (bus.ld_req_i) begin
        if ({bus.ram_en_o, bus.ram_we_o, bus.ram_be_o, bus.ram_addr_o, bus.ram_wdata_o} !==
            {1'b1, 1'b1, bus.ld_be_i, bus.ld_addr_i[AW-1:2], 2'b00, bus.ld_wdata_i}) begin
          errors++; $display("FAIL mon_load: got en%b we%b be%h addr%h wd%h", bus.ram_en_o,
                             bus.ram_we_o, bus.ram_be_o, bus.ram_addr_o, bus.ram_wdata_o);
        end
      end else if (bus.branch_i) begin
        if ({bus.ram_en_o, bus.ram_we_o, bus.ram_be_o, bus.ram_addr_o} !== {1'b1, 1'b0, 4'hF, m_tgt}) begin
          errors++; $display("FAIL mon_branch_read: got en%b we%b be%h addr%h want addr %h",
                             bus.ram_en_o, bus.ram_we_o, bus.ram_be_o, bus.ram_addr_o, m_tgt);
        end
      end else if (m_credit) begin
        if ({bus.ram_en_o, bus.ram_we_o, bus.ram_be_o, bus.ram_addr_o} !== {1'b1, 1'b0, 4'hF, m_issue}) begin
          errors++; $display("FAIL mon_seq_read: got en%b we%b be%h addr%h want addr %h",
                             bus.ram_en_o, bus.ram_we_o, bus.ram_be_o, bus.ram_addr_o, m_issue);
        end
      end else begin
        if (bus.ram_en_o !== 1'b0) begin
          errors++; $display("FAIL mon_idle: got ram_en %b want 0 (outstanding %0d)", bus.ram_en_o, m_out);
        end
      end
      if (bus.branch_i) begin
        m_exp   = m_tgt;
        m_out   = bus.ld_req_i ? 0 : 1;
        m_issue = bus.ld_req_i ? m_tgt : m_tgt + AW'(4);
      end else if (!bus.ld_req_i && m_credit) begin
        m_out++;
        m_issue = m_issue + AW'(4);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.fetch_en_i = 1'b1; bus.instr_ready_i = 1'b1; bus.branch_i = 1'b0;
    bus.ld_req_i = 1'b1; bus.ld_addr_i = AW'(32'h44); bus.ld_be_i = 4'hF; bus.ld_wdata_i = $urandom;
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.instr_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.instr_valid_o); end
    checks++; if (bus.instr_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", bus.instr_rdata_o); end
    checks++; if (bus.instr_addr_o !== '0) begin errors++; $display("FAIL reset_iaddr: got %h want 0", bus.instr_addr_o); end
    checks++; if (bus.ram_en_o !== 1'b0) begin errors++; $display("FAIL reset_ram_en: got %b want 0", bus.ram_en_o); end
    checks++; if (bus.ram_we_o !== 1'b0) begin errors++; $display("FAIL reset_ram_we: got %b want 0", bus.ram_we_o); end
    checks++; if (bus.ram_be_o !== 4'h0) begin errors++; $display("FAIL reset_ram_be: got %h want 0", bus.ram_be_o); end
    checks++; if (bus.ram_addr_o !== '0) begin errors++; $display("FAIL reset_ram_addr: got %h want 0", bus.ram_addr_o); end
    checks++; if (bus.ram_wdata_o !== 32'h0) begin errors++; $display("FAIL reset_ram_wdata: got %h want 0", bus.ram_wdata_o); end
    checks++; if (bus.ld_gnt_o !== 1'b1) begin errors++; $display("FAIL reset_gnt_hi: got %b want 1", bus.ld_gnt_o); end
    bus.ld_req_i = 1'b0;
    #1;
    checks++; if (bus.ld_gnt_o !== 1'b0) begin errors++; $display("FAIL reset_gnt_lo: got %b want 0", bus.ld_gnt_o); end
  endtask

  task automatic test_first_fetch();
    tick();
    rstn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (bus.ram_en_o !== 1'b1 || bus.ram_addr_o !== AW'(4*c)) begin
        errors++; $display("FAIL first_read_%0d: got en %b addr %h want en 1 addr %h", c, bus.ram_en_o, bus.ram_addr_o, AW'(4*c));
      end
      checks++;
      if (c < 2) begin
        if (bus.instr_valid_o !== 1'b0) begin errors++; $display("FAIL first_latency_%0d: got valid %b want 0", c, bus.instr_valid_o); end
      end else if (bus.instr_valid_o !== 1'b1 || bus.instr_addr_o !== AW'(4*(c-2))) begin
        errors++; $display("FAIL first_word_%0d: got valid %b addr %h want valid 1 addr %h", c, bus.instr_valid_o, bus.instr_addr_o, AW'(4*(c-2)));
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int   reads = 0;
    logic last_en = 1'b1;
    bus.instr_ready_i = 1'b0;
    bus.branch_i = 1'b1; bus.branch_addr_i = AW'(32'h200);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.ram_en_o && !bus.ram_we_o) reads++;
      last_en = bus.ram_en_o;
      tick();
      bus.branch_i = 1'b0;
    end
    checks++; if (reads != int'(DEPTH)) begin errors++; $display("FAIL bp_read_count: got %0d want %0d", reads, DEPTH); end
    checks++; if (last_en !== 1'b0) begin errors++; $display("FAIL bp_stalled: got ram_en %b want 0", last_en); end
    bus.instr_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.instr_valid_o !== 1'b1 || bus.instr_addr_o !== AW'(32'h200 + 4*i)) begin
        errors++; $display("FAIL bp_drain_%0d: got valid %b addr %h want valid 1 addr %h", i, bus.instr_valid_o, bus.instr_addr_o, AW'(32'h200 + 4*i));
      end
      tick();
    end
  endtask

  task automatic test_branch();
    bus.instr_ready_i = 1'b0;
    bus.branch_i = 1'b1; bus.branch_addr_i = AW'(32'h400);
    tick();
    bus.branch_i = 1'b0;
    tick(); tick(); tick();
    bus.branch_i = 1'b1; bus.branch_addr_i = AW'(32'h101);
    @(negedge clk);
    checks++;
    if (bus.instr_valid_o !== 1'b1 || bus.instr_addr_o !== AW'(32'h400)) begin
      errors++; $display("FAIL br_prefill: got valid %b addr %h want valid 1 addr 400", bus.instr_valid_o, bus.instr_addr_o);
    end
    checks++;
    if (bus.ram_en_o !== 1'b1 || bus.ram_addr_o !== AW'(32'h100)) begin
      errors++; $display("FAIL br_read: got en %b addr %h want en 1 addr 100", bus.ram_en_o, bus.ram_addr_o);
    end
    tick();
    bus.branch_i = 1'b0;
    @(negedge clk);
    checks++; if (bus.instr_valid_o !== 1'b0) begin errors++; $display("FAIL br_flushed: got valid %b want 0", bus.instr_valid_o); end
    tick();
    bus.instr_ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.instr_valid_o !== 1'b1 || bus.instr_addr_o !== AW'(32'h100)) begin
      errors++; $display("FAIL br_first: got valid %b addr %h want valid 1 addr 100", bus.instr_valid_o, bus.instr_addr_o);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.instr_valid_o !== 1'b1 || bus.instr_addr_o !== AW'(32'h104)) begin
      errors++; $display("FAIL br_second: got valid %b addr %h want valid 1 addr 104", bus.instr_valid_o, bus.instr_addr_o);
    end
    tick();
  endtask

  task automatic test_loader();
    logic [31:0] old_w;
    logic [31:0] wd;
    int          seen = 0;
    bus.instr_ready_i = 1'b1;
    repeat (6) tick();
    old_w = mem[16];
    wd    = $urandom;
    bus.ld_req_i = 1'b1; bus.ld_addr_i = AW'(32'h42); bus.ld_be_i = 4'b0011; bus.ld_wdata_i = wd;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.ld_gnt_o, bus.ram_en_o, bus.ram_we_o, bus.ram_be_o, bus.ram_addr_o, bus.ram_wdata_o} !==
          {1'b1, 1'b1, 1'b1, 4'b0011, AW'(32'h40), wd}) begin
        errors++; $display("FAIL ld_write_%0d: got gnt %b en %b we %b be %b addr %h wd %h want 1 1 1 0011 40 %h", c,
                           bus.ld_gnt_o, bus.ram_en_o, bus.ram_we_o, bus.ram_be_o, bus.ram_addr_o, bus.ram_wdata_o, wd);
      end
      tick();
    end
    bus.ld_req_i = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.instr_valid_o) seen++;
      tick();
    end
    checks++; if (seen < 5) begin errors++; $display("FAIL ld_resume: got %0d valid cycles want at least 5", seen); end
    bus.ld_req_i = 1'b1; bus.ld_addr_i = AW'(32'h6000); bus.ld_be_i = 4'hF; bus.ld_wdata_i = $urandom;
    bus.branch_i = 1'b1; bus.branch_addr_i = AW'(32'h300);
    tick();
    bus.ld_req_i = 1'b0; bus.branch_i = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.ram_en_o !== 1'b1 || bus.ram_we_o !== 1'b0 || bus.ram_addr_o !== AW'(32'h300)) begin
      errors++; $display("FAIL ld_branch_pc: got en %b we %b addr %h want 1 0 300", bus.ram_en_o, bus.ram_we_o, bus.ram_addr_o);
    end
    tick();
    bus.instr_ready_i = 1'b0;
    bus.branch_i = 1'b1; bus.branch_addr_i = AW'(32'h40);
    tick();
    bus.branch_i = 1'b0;
    for (int c = 0; c < 10 && !bus.instr_valid_o; c++) tick();
    @(negedge clk);
    checks++;
    if (bus.instr_valid_o !== 1'b1 || bus.instr_addr_o !== AW'(32'h40) || bus.instr_rdata_o !== {old_w[31:16], wd[15:0]}) begin
      errors++; $display("FAIL ld_readback: got valid %b addr %h data %h want 1 40 %h", bus.instr_valid_o,
                         bus.instr_addr_o, bus.instr_rdata_o, {old_w[31:16], wd[15:0]});
    end
    tick();
    bus.instr_ready_i = 1'b1;
  endtask

  task automatic test_wrap();
    logic [AW-1:0] got [3];
    int            n = 0;
    bus.instr_ready_i = 1'b1;
    bus.branch_i = 1'b1; bus.branch_addr_i = AW'(32'h7FF8);
    tick();
    bus.branch_i = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.instr_valid_o && n < 3) begin got[n] = bus.instr_addr_o; n++; end
      tick();
    end
    checks++;
    if (n != 3) begin
      errors++; $display("FAIL wrap_count: got %0d words want 3", n);
    end else begin
      checks++;
      if (got[0] !== AW'(32'h7FF8) || got[1] !== AW'(32'h7FFC) || got[2] !== AW'(0)) begin
        errors++; $display("FAIL wrap_order: got %h %h %h want 7ff8 7ffc 0000", got[0], got[1], got[2]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bus.instr_ready_i = 1'b1; bus.fetch_en_i = 1'b1;
    repeat (5) tick();
    #3 rstn = 1'b0;
    #1;
    checks++;
    if ({bus.instr_valid_o, bus.instr_rdata_o, bus.instr_addr_o, bus.ram_en_o, bus.ram_be_o, bus.ram_addr_o} !== '0) begin
      errors++; $display("FAIL rst_async: got valid %b rdata %h iaddr %h en %b be %h addr %h want all 0",
                         bus.instr_valid_o, bus.instr_rdata_o, bus.instr_addr_o, bus.ram_en_o, bus.ram_be_o, bus.ram_addr_o);
    end
    tick();
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.ram_en_o !== 1'b1 || bus.ram_addr_o !== AW'(BOOT)) begin
      errors++; $display("FAIL rst_restart: got en %b addr %h want en 1 addr %h", bus.ram_en_o, bus.ram_addr_o, AW'(BOOT));
    end
    tick(); tick();
    @(negedge clk);
    checks++;
    if (bus.instr_valid_o !== 1'b1 || bus.instr_addr_o !== AW'(BOOT)) begin
      errors++; $display("FAIL rst_first_word: got valid %b addr %h want 1 %h", bus.instr_valid_o, bus.instr_addr_o, AW'(BOOT));
    end
    tick();
  endtask

  task automatic test_random();
    int since = 0;
    int pops  = 0;
    for (int c = 0; c < 1500; c++) begin
      bus.instr_ready_i = ($urandom_range(0, 3) != 0);
      bus.fetch_en_i    = ($urandom_range(0, 7) != 0);
      bus.branch_i      = 1'b0;
      since++;
      if ($urandom_range(0, 23) == 0 || since >= 60) begin
        since = 0;
        bus.branch_i = 1'b1;
        bus.branch_addr_i = ($urandom_range(0, 7) == 0) ? AW'(32'h7FE0 + $urandom_range(0, 7))
                                                         : AW'($urandom_range(0, 32'h4FFF));
      end
      bus.ld_req_i   = ($urandom_range(0, 7) == 0);
      bus.ld_addr_i  = AW'(32'h6000 + $urandom_range(0, 32'hFFF));
      bus.ld_be_i    = 4'($urandom);
      bus.ld_wdata_i = $urandom;
      @(negedge clk);
      if (bus.instr_valid_o && bus.instr_ready_i) pops++;
      tick();
    end
    bus.branch_i = 1'b0; bus.ld_req_i = 1'b0;
    checks++; if (pops < 400) begin errors++; $display("FAIL rand_progress: got %0d words want at least 400", pops); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < int'(WORDS); i++) mem[i] = $urandom;
    rstn = 1'b0;
    bus.fetch_en_i = 1'b0; bus.branch_i = 1'b0; bus.branch_addr_i = '0; bus.instr_ready_i = 1'b0;
    bus.ld_req_i = 1'b0; bus.ld_addr_i = '0; bus.ld_wdata_i = '0; bus.ld_be_i = '0;
    test_reset();
    test_first_fetch();
    test_backpressure();
    test_branch();
    test_loader();
    test_wrap();
    test_reset_mid();
    test_random();
    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
